ahbl_xbar_1to_n: RTL and testbench

- Parametrised single-master to N-slave AHB-Lite interconnect with a configurable address map: base and mask per slave.
- Tracks the data phase and muxes HRDATA, HREADY and HRESP back to the master.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped accesses.
- Logs the error count and the address of the last faulting transfer for the SoC debug registers. Sits between the core's AHB-Lite master port and the peripheral/memory slaves.

---
 rtl/ahbl_xbar_1to_n_pkg.sv | 34 +++
 rtl/ahbl_xbar_1to_n_default_slave.sv | 53 +++++
 rtl/ahbl_xbar_1to_n.sv | 141 ++++++++++++++
 tb/tb_ahbl_xbar_1to_n.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_xbar_1to_n_pkg.sv
// Shared AHB-Lite constants, default-slave state encoding and the default
// address map (slave i at i*2^28, 256 MB windows).
package ahbl_xbar_1to_n_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int MAX_SLAVES     = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] ds_state_t;
    localparam ds_state_t DS_IDLE = 2'd0;
    localparam ds_state_t DS_ERR1 = 2'd1;
    localparam ds_state_t DS_ERR2 = 2'd2;

    function automatic logic [MAX_SLAVES*DEF_ADDR_WIDTH-1:0] default_base();
        logic [MAX_SLAVES*DEF_ADDR_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_SLAVES; i++)
            v[i*DEF_ADDR_WIDTH +: DEF_ADDR_WIDTH] = DEF_ADDR_WIDTH'(i) << 28;
        return v;
    endfunction

    localparam logic [MAX_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_BASE = default_base();
    localparam logic [MAX_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_MASK =
        {MAX_SLAVES{32'hF000_0000}};

endpackage

// File: rtl/ahbl_xbar_1to_n_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response for active
// transfers, zero-wait OKAY otherwise, plus error counter and fault address log.
module ahbl_default_slave
    import ahbl_xbar_1to_n_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_hready,
    input  logic                    i_unmapped,
    input  logic                    i_active,
    input  logic [ADDR_WIDTH-1:0]   i_haddr,
    output logic                    o_hready,
    output logic                    o_hresp,
    output logic [ERRCNT_WIDTH-1:0] o_err_count,
    output logic [ADDR_WIDTH-1:0]   o_err_addr
);

    ds_state_t               r_state;
    logic [ERRCNT_WIDTH-1:0] r_err_count;
    logic [ADDR_WIDTH-1:0]   r_err_addr;
    logic                    w_err_start;

    // i_hready is low throughout DS_ERR1, so a cancelling IDLE cannot cut it short.
    assign w_err_start = i_hready && i_unmapped && i_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DS_IDLE;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            case (r_state)
                DS_IDLE, DS_ERR2: r_state <= w_err_start ? DS_ERR1 : DS_IDLE;
                DS_ERR1:          r_state <= DS_ERR2;
                default:          r_state <= DS_IDLE;
            endcase
            if (w_err_start) begin
                r_err_addr <= i_haddr;
                if (r_err_count != {ERRCNT_WIDTH{1'b1}})
                    r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
            end
        end
    end

    assign o_hready    = (r_state != DS_ERR1);
    assign o_hresp     = (r_state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    assign o_err_count = r_err_count;
    assign o_err_addr  = r_err_addr;

endmodule

// File: rtl/ahbl_xbar_1to_n.sv
// Single-master to N-slave AHB-Lite interconnect: base/mask address decode,
// data-phase tracking and response mux, with a built-in default slave.
module ahbl_xbar_1to_n
    import ahbl_xbar_1to_n_pkg::*;
#(
    parameter int NUM_SLAVES   = 15,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        DEF_SLAVE_BASE[NUM_SLAVES*ADDR_WIDTH-1:0],
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        DEF_SLAVE_MASK[NUM_SLAVES*ADDR_WIDTH-1:0],
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          m_haddr,
    input  logic [1:0]                     m_htrans,
    input  logic                           m_hwrite,
    input  logic [2:0]                     m_hsize,
    input  logic [2:0]                     m_hburst,
    input  logic [3:0]                     m_hprot,
    input  logic                           m_hmastlock,
    input  logic [DATA_WIDTH-1:0]          m_hwdata,
    output logic [DATA_WIDTH-1:0]          m_hrdata,
    output logic                           m_hready,
    output logic                           m_hresp,
    output logic [NUM_SLAVES-1:0]          s_hsel,
    output logic [ADDR_WIDTH-1:0]          s_haddr,
    output logic [1:0]                     s_htrans,
    output logic                           s_hwrite,
    output logic [2:0]                     s_hsize,
    output logic [2:0]                     s_hburst,
    output logic [3:0]                     s_hprot,
    output logic                           s_hmastlock,
    output logic [DATA_WIDTH-1:0]          s_hwdata,
    output logic                           s_hready,
    input  logic [NUM_SLAVES-1:0]          s_hreadyout,
    input  logic [NUM_SLAVES-1:0]          s_hresp,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
    output logic [ERRCNT_WIDTH-1:0]        err_count,
    output logic [ADDR_WIDTH-1:0]          err_addr
);

    localparam int SIDX_W = $clog2(NUM_SLAVES + 1);
    localparam logic [SIDX_W-1:0] DEF_IDX = SIDX_W'(NUM_SLAVES);

    logic [SIDX_W-1:0]     w_dec_idx;
    logic                  w_unmapped;
    logic                  w_active;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DATA_WIDTH-1:0] w_hrdata;
    logic                  w_ds_hready;
    logic                  w_ds_hresp;

    logic                  r_dsel_vld;
    logic [SIDX_W-1:0]     r_dsel;
    logic                  r_dwrite;

    // Scanning downwards lets the lowest matching index win on overlap.
    always_comb begin
        w_dec_idx = DEF_IDX;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_haddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                w_dec_idx = SIDX_W'(i);
        end
    end

    always_comb begin
        s_hsel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            s_hsel[i] = (w_dec_idx == SIDX_W'(i));
    end

    assign w_unmapped = (w_dec_idx == DEF_IDX);
    assign w_active   = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dsel_vld <= 1'b0;
            r_dsel     <= '0;
            r_dwrite   <= 1'b0;
        end else if (w_hready) begin
            r_dsel_vld <= 1'b1;
            r_dsel     <= w_dec_idx;
            r_dwrite   <= m_hwrite;
        end
    end

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (r_dsel_vld) begin
            if (r_dsel == DEF_IDX) begin
                w_hready = w_ds_hready;
                w_hresp  = w_ds_hresp;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_dsel == SIDX_W'(i)) begin
                        w_hready = s_hreadyout[i];
                        w_hresp  = s_hresp[i];
                        w_hrdata = r_dwrite ? '0 : s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    ahbl_default_slave #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .ERRCNT_WIDTH (ERRCNT_WIDTH)
    ) u_default_slave (
        .clk         (clk),
        .rst         (rst),
        .i_hready    (w_hready),
        .i_unmapped  (w_unmapped),
        .i_active    (w_active),
        .i_haddr     (m_haddr),
        .o_hready    (w_ds_hready),
        .o_hresp     (w_ds_hresp),
        .o_err_count (err_count),
        .o_err_addr  (err_addr)
    );

    assign m_hready    = w_hready;
    assign m_hresp     = w_hresp;
    assign m_hrdata    = w_hrdata;
    assign s_hready    = w_hready;
    assign s_haddr     = m_haddr;
    assign s_htrans    = m_htrans;
    assign s_hwrite    = m_hwrite;
    assign s_hsize     = m_hsize;
    assign s_hburst    = m_hburst;
    assign s_hprot     = m_hprot;
    assign s_hmastlock = m_hmastlock;
    assign s_hwdata    = m_hwdata;

endmodule

// File: tb/tb_ahbl_xbar_1to_n.sv
// Randomised scoreboard bench for ahbl_xbar_1to_n with a transaction-level
// reference model of the address map, data phases and default slave.
module tb_ahbl_xbar_1to_n;

    localparam int NS  = 15;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int ECW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     m_haddr;
    logic [1:0]        m_htrans;
    logic              m_hwrite;
    logic [2:0]        m_hsize;
    logic [2:0]        m_hburst;
    logic [3:0]        m_hprot;
    logic              m_hmastlock;
    logic [DW-1:0]     m_hwdata;
    logic [DW-1:0]     m_hrdata;
    logic              m_hready;
    logic              m_hresp;
    logic [NS-1:0]     s_hsel;
    logic [AW-1:0]     s_haddr;
    logic [1:0]        s_htrans;
    logic              s_hwrite;
    logic [2:0]        s_hsize;
    logic [2:0]        s_hburst;
    logic [3:0]        s_hprot;
    logic              s_hmastlock;
    logic [DW-1:0]     s_hwdata;
    logic              s_hready;
    logic [NS-1:0]     slv_rdy;
    logic [NS-1:0]     slv_resp;
    logic [NS*DW-1:0]  slv_rdata;
    logic [ECW-1:0]    err_count;
    logic [AW-1:0]     err_addr;

    ahbl_xbar_1to_n #(
        .NUM_SLAVES   (NS),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .ERRCNT_WIDTH (ECW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_haddr     (m_haddr),
        .m_htrans    (m_htrans),
        .m_hwrite    (m_hwrite),
        .m_hsize     (m_hsize),
        .m_hburst    (m_hburst),
        .m_hprot     (m_hprot),
        .m_hmastlock (m_hmastlock),
        .m_hwdata    (m_hwdata),
        .m_hrdata    (m_hrdata),
        .m_hready    (m_hready),
        .m_hresp     (m_hresp),
        .s_hsel      (s_hsel),
        .s_haddr     (s_haddr),
        .s_htrans    (s_htrans),
        .s_hwrite    (s_hwrite),
        .s_hsize     (s_hsize),
        .s_hburst    (s_hburst),
        .s_hprot     (s_hprot),
        .s_hmastlock (s_hmastlock),
        .s_hwdata    (s_hwdata),
        .s_hready    (s_hready),
        .s_hreadyout (slv_rdy),
        .s_hresp     (slv_resp),
        .s_hrdata    (slv_rdata),
        .err_count   (err_count),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          wr;
        bit          act;
        logic [31:0] addr;
    } rec_t;

    rec_t           q[$];
    int             tests = 0;
    int             fails = 0;
    int             ds_phase = 0;
    bit             mon_en = 1'b0;
    bit             hold_slv = 1'b0;
    logic [ECW-1:0] err_exp = '0;
    logic [AW-1:0]  err_addr_exp = '0;

    // Default map: slave n owns the 256 MB window whose top nibble is n; nibble 15 is unmapped.
    function automatic int ref_slave(input logic [31:0] a);
        int nib;
        nib = int'(a[31:28]);
        return (nib < NS) ? nib : NS;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Master driver: present an address phase, hold it until HREADY, then log it.
    task automatic xfer(input logic [31:0] a, input logic [1:0] tr, input logic wr);
        rec_t r;
        int   n;
        logic acc;
        m_haddr     = a;
        m_htrans    = tr;
        m_hwrite    = wr;
        m_hsize     = 3'd2;
        m_hburst    = 3'($urandom);
        m_hprot     = 4'($urandom);
        m_hmastlock = 1'($urandom);
        m_hwdata    = $urandom;
        n = 0;
        forever begin
            @(negedge clk);
            acc = m_hready;
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 64) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: addr %0h still waiting after %0d cycles", a, n);
                break;
            end
        end
        r.idx  = ref_slave(a);
        r.wr   = wr;
        r.act  = (tr == 2'd2) || (tr == 2'd3);
        r.addr = a;
        q.push_back(r);
        if (r.idx == NS && r.act) begin
            if (err_exp != {ECW{1'b1}}) err_exp = err_exp + 1'b1;
            err_addr_exp = a;
        end
        #1;
    endtask

    // Random slave responses, refreshed each cycle unless a directed test owns them.
    always @(posedge clk) begin
        #2;
        if (!hold_slv) begin
            for (int i = 0; i < NS; i++) begin
                slv_rdy[i]  = ($urandom_range(3) != 0);
                slv_resp[i] = ($urandom_range(7) == 0);
                slv_rdata[i*DW +: DW] = $urandom;
            end
        end
    end

    // Monitor: the front of the queue is the transfer currently in its data phase.
    always @(negedge clk) begin
        logic [NS-1:0] hs;
        logic          er;
        logic          es;
        logic [31:0]   ed;
        rec_t          r;
        int            e;
        if (mon_en) begin
            e  = ref_slave(m_haddr);
            hs = '0;
            if (e < NS) hs[e] = 1'b1;
            chk("s_hsel", 64'(s_hsel), 64'(hs));
            chk("s_haddr", 64'(s_haddr), 64'(m_haddr));
            chk("s_hwdata", 64'(s_hwdata), 64'(m_hwdata));
            chk("s_ctrl", 64'({s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock}),
                64'({m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot, m_hmastlock}));
            er = 1'b1;
            es = 1'b0;
            ed = '0;
            if (q.size() > 0) begin
                r = q[0];
                if (r.idx < NS) begin
                    er = slv_rdy[r.idx];
                    es = slv_resp[r.idx];
                    ed = r.wr ? 32'h0 : slv_rdata[r.idx*DW +: DW];
                end else if (r.act) begin
                    er = (ds_phase != 0);
                    es = 1'b1;
                end
            end
            chk("m_hready", 64'(m_hready), 64'(er));
            chk("s_hready", 64'(s_hready), 64'(er));
            chk("m_hresp", 64'(m_hresp), 64'(es));
            chk("m_hrdata", 64'(m_hrdata), 64'(ed));
            chk("err_count", 64'(err_count), 64'(err_exp));
            chk("err_addr", 64'(err_addr), 64'(err_addr_exp));
            if (q.size() > 0) begin
                if (er) begin
                    void'(q.pop_front());
                    ds_phase = 0;
                end else if (r.idx == NS) begin
                    ds_phase = 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  nib;
        rst = 1'b1;
        m_haddr = '0; m_htrans = 2'd0; m_hwrite = 1'b0; m_hsize = 3'd2;
        m_hburst = 3'd0; m_hprot = 4'd0; m_hmastlock = 1'b0; m_hwdata = '0;
        slv_rdy = '1; slv_resp = '0; slv_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hready", 64'(m_hready), 64'(1));
        chk("reset_hresp", 64'(m_hresp), 64'(0));
        chk("reset_hrdata", 64'(m_hrdata), 64'(0));
        chk("reset_err_count", 64'(err_count), 64'(0));
        chk("reset_err_addr", 64'(err_addr), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            nib = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(NS - 1));
            a = {nib, 28'($urandom)};
            xfer(a, 2'($urandom), 1'($urandom));
        end
        xfer(32'h0000_0000, 2'd0, 1'b0);
        xfer(32'h0000_0000, 2'd0, 1'b0);

        // Reset asserted while slave 5 is inserting wait states.
        hold_slv = 1'b1;
        slv_rdy = '1; slv_resp = '0;
        xfer(32'h5000_0040, 2'd2, 1'b0);
        slv_rdy[5] = 1'b0;
        m_haddr = 32'h3000_0010;
        m_htrans = 2'd0;
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_hready", 64'(m_hready), 64'(1));
        chk("rst_hresp", 64'(m_hresp), 64'(0));
        chk("rst_s_hready", 64'(s_hready), 64'(1));
        chk("rst_s_hsel", 64'(s_hsel), 64'h0008);
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_err_addr", 64'(err_addr), 64'(0));
        q.delete();
        ds_phase = 0;
        err_exp = '0;
        err_addr_exp = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        slv_rdy = '1;
        slv_rdata[3*DW +: DW] = 32'hDEAD_BEEF;
        xfer(32'h3000_0010, 2'd2, 1'b0);
        xfer(32'hF000_0000, 2'd2, 1'b0);
        xfer(32'hF000_0004, 2'd3, 1'b0);
        xfer(32'hF000_0000, 2'd0, 1'b0);
        xfer(32'h0000_0000, 2'd2, 1'b1);
        xfer(32'h1000_0000, 2'd2, 1'b0);
        xfer(32'h0000_0000, 2'd0, 1'b0);
        xfer(32'h0000_0000, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("final_err_count", 64'(err_count), 64'(2));
        chk("final_err_addr", 64'(err_addr), 64'h0000_0000_F000_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
